// File: rtl/mul_pkg.sv
// mul_pkg
// Shared definitions for the iterative RV32M multiplier issue slice:
// default datapath width, the funct3 codes the block understands and the
// controller state encoding.
package mul_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add
// Unsigned shift-add multiplier core: one multiplier bit per step, LSB first,
// into a 2*XLEN-bit accumulator. Sign handling lives in the caller.
//
// Ports
//   Clk, Rst        clock, asynchronous active-high reset
//   start           load magnitudes, clear accumulator and counter
//   step            perform one shift-add iteration
//   a_mag, b_mag    unsigned multiplicand / multiplier magnitudes
//   done            high on the step that consumes the last multiplier bit
//   product         accumulator contents (final product after last step)
module mul_shift_add
    import mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                start,
    input  logic                step,
    input  logic [XLEN-1:0]     a_mag,
    input  logic [XLEN-1:0]     b_mag,
    output logic                done,
    output logic [2*XLEN-1:0]   product
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;

    assign done    = step && (cnt == CNT_W'(XLEN - 1));
    assign product = acc;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
// Issue/handshake controller for an iterative RV32M multiply unit. Accepts one
// request at a time, converts operands to magnitudes, runs the shift-add core,
// applies the sign fix-up and presents the selected product half.
//
// Ports
//   Clk, Rst                clock, asynchronous active-high reset
//   in_valid / in_ready     request handshake (in_ready only in IDLE)
//   funct3, rs1, rs2        operation and operands
//   in_tag                  destination tag carried through
//   out_valid / out_ready   result handshake (out_valid only in DONE)
//   result, out_tag         selected product half and its tag
//   out_err                 request had an unsupported funct3 (bit 2 set)
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | one shift-add step per cycle, XLEN cycles
// FIX   | sign fix-up and half select into the output registers
// DONE  | result presented, waiting for out_ready
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    state_t state, state_nxt;

    logic start, step, load_res, calc_done;
    logic a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] product, fixed;
    logic [XLEN-1:0]   result_nxt;

    logic             neg_q;
    logic [2:0]       f3_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        load_res  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    start     = 1'b1;
                    // Unsupported ops skip the multiply entirely.
                    state_nxt = funct3[2] ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (calc_done) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                load_res  = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand signedness: rs1 signed for MUL/MULH/MULHSU, rs2 for MUL/MULH.
    // Unary minus of the most negative value yields the same bit pattern,
    // which is exactly its unsigned magnitude.
    always_comb begin
        a_neg = rs1[XLEN-1] && ((funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                                (funct3 == F3_MULHSU));
        b_neg = rs2[XLEN-1] && ((funct3 == F3_MUL) || (funct3 == F3_MULH));
        a_mag = a_neg ? -rs1 : rs1;
        b_mag = b_neg ? -rs2 : rs2;
    end

    mul_shift_add #(.XLEN(XLEN)) u_core (
        .Clk     (Clk),
        .Rst     (Rst),
        .start   (start),
        .step    (step),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .done    (calc_done),
        .product (product)
    );

    // Negating zero gives zero, so a zero product with neg_q set stays 0.
    always_comb begin
        fixed = neg_q ? -product : product;
        if (f3_q[2]) begin
            result_nxt = '0;
        end else if (f3_q == F3_MUL) begin
            result_nxt = fixed[XLEN-1:0];
        end else begin
            result_nxt = fixed[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            neg_q   <= 1'b0;
            f3_q    <= 3'b000;
            tag_q   <= '0;
            result  <= '0;
            out_tag <= '0;
            out_err <= 1'b0;
        end else begin
            if (start) begin
                neg_q <= a_neg ^ b_neg;
                f3_q  <= funct3;
                tag_q <= in_tag;
            end
            if (load_res) begin
                result  <= result_nxt;
                out_tag <= tag_q;
                out_err <= f3_q[2];
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl
// Directed bench for mul_issue_ctrl. Inputs are driven and outputs sampled on
// the falling edge. Latency is the number of the first rising edge after the
// accepting edge at which out_valid is seen high (sampled on the falling edge
// just before it).
module tb_mul_issue_ctrl;

    logic        Clk;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    mul_issue_ctrl #(.XLEN(32), .TAG_W(5)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the DUT idle.
    task automatic run_req(input string name, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] exp_res,
                           input logic exp_err, input int exp_lat, input int hold);
        int n;
        chk({name, ".in_ready_idle"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        in_tag   = tag;
        @(posedge Clk);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                chk({name, ".in_ready_busy"}, 64'(in_ready), 64'(0));
                // Busy-time requests with scrambled fields must be ignored.
                in_valid = (exp_lat > 4);
                funct3   = 3'b011;
                rs1      = ~a;
                rs2      = ~b;
                in_tag   = ~tag;
            end
            if (n == 4) in_valid = 1'b0;
        end while (out_valid !== 1'b1 && n < 200);
        in_valid = 1'b0;
        chk({name, ".latency"}, 64'(n), 64'(exp_lat));
        chk({name, ".result"}, 64'(result), 64'(exp_res));
        chk({name, ".out_tag"}, 64'(out_tag), 64'(tag));
        chk({name, ".out_err"}, 64'(out_err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            chk({name, ".hold_valid"}, 64'(out_valid), 64'(1));
            chk({name, ".hold_result"}, 64'(result), 64'(exp_res));
            chk({name, ".hold_tag"}, 64'(out_tag), 64'(tag));
            chk({name, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        chk({name, ".in_ready_after"}, 64'(in_ready), 64'(1));
        chk({name, ".out_valid_after"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int seen;
        Rst       = 1'b1;
        in_valid  = 1'b0;
        funct3    = 3'b000;
        rs1       = '0;
        rs2       = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge Clk);
        // out_ready high during reset and idle must do nothing.
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.result", 64'(result), 64'(0));
        chk("rst.out_tag", 64'(out_tag), 64'(0));
        chk("rst.out_err", 64'(out_err), 64'(0));
        out_ready = 1'b0;
        Rst = 1'b0;

        // First request accepted on the first edge after reset release.
        run_req("mul_120x29", 3'b000, 32'd120, 32'd29, 5'h13, 32'h00000D98, 1'b0, 34, 0);
        run_req("mulh_min_min", 3'b001, 32'h80000000, 32'h80000000, 5'h01, 32'h40000000, 1'b0, 34, 0);
        run_req("mulh_m1_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'h00000000, 1'b0, 34, 0);
        run_req("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 1'b0, 34, 0);
        run_req("mulhsu_m1_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 32'hFFFFFFFF, 1'b0, 34, 0);
        run_req("mul_neg_hold", 3'b000, 32'hFFFFFFFD, 32'd7, 5'h05, 32'hFFFFFFEB, 1'b0, 34, 10);
        run_req("mul_min_m1", 3'b000, 32'h80000000, 32'hFFFFFFFF, 5'h06, 32'h80000000, 1'b0, 34, 0);
        run_req("mulh_zero_neg", 3'b001, 32'h00000000, 32'hFFFFFFFB, 5'h07, 32'h00000000, 1'b0, 34, 0);
        run_req("mulhsu_m2_3", 3'b010, 32'hFFFFFFFE, 32'd3, 5'h08, 32'hFFFFFFFF, 1'b0, 34, 0);
        run_req("mulhu_min_2", 3'b011, 32'h80000000, 32'd2, 5'h09, 32'h00000001, 1'b0, 34, 0);
        run_req("illegal_100", 3'b100, 32'd5, 32'd7, 5'h1F, 32'h00000000, 1'b1, 2, 2);
        run_req("illegal_111", 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h0A, 32'h00000000, 1'b1, 2, 0);

        // Reset in the middle of CALC discards the request.
        in_valid = 1'b1;
        funct3   = 3'b000;
        rs1      = 32'd1000;
        rs2      = 32'd1000;
        in_tag   = 5'h0B;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("midrst.in_ready", 64'(in_ready), 64'(1));
        chk("midrst.out_valid", 64'(out_valid), 64'(0));
        chk("midrst.result", 64'(result), 64'(0));
        chk("midrst.out_tag", 64'(out_tag), 64'(0));
        @(negedge Clk);
        Rst  = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge Clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst.no_out_valid", 64'(seen), 64'(0));
        run_req("mul_84x30", 3'b000, 32'd84, 32'd30, 5'h0C, 32'h000009D8, 1'b0, 34, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
